// File: rtl/program_sequencer_stack_pkg.sv
// ============================================================================
// Module      : program_sequencer_pkg
// Description : Strobe priority encoding and jump-target helper for the
//               program sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package program_sequencer_pkg;

    typedef logic [2:0] sel_t;

    localparam sel_t SEL_HOLD = 3'd0;
    localparam sel_t SEL_RET  = 3'd1;
    localparam sel_t SEL_CALL = 3'd2;
    localparam sel_t SEL_JMP  = 3'd3;
    localparam sel_t SEL_JNZ  = 3'd4;
    localparam sel_t SEL_INC  = 3'd5;

    // Jump targets place jmp_addr in the top bits of the PC; callers truncate to PC_W.
    function automatic logic [31:0] target_addr(input logic [31:0] jmp_addr,
                                                input int          pc_w,
                                                input int          jmp_w);
        return jmp_addr << (pc_w - jmp_w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/program_sequencer_stack_if.sv
// ============================================================================
// Module      : program_sequencer_stack_if
// Description : Decoder-side control strobes and program-memory side outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface program_sequencer_stack_if #(
    parameter int PC_W        = 8,
    parameter int JMP_W       = 4,
    parameter int STACK_DEPTH = 4
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    logic             hold;
    logic             jmp;
    logic             jmp_nz;
    logic             dont_jmp;
    logic             call;
    logic             ret;
    logic             clr_err;
    logic [JMP_W-1:0] jmp_addr;
    logic [PC_W-1:0]  pm_addr;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  from_PS;
    logic [SP_W-1:0]  sp;
    logic             stk_ovf;
    logic             stk_unf;

    modport master (
        output hold, jmp, jmp_nz, dont_jmp, call, ret, clr_err, jmp_addr,
        input  pm_addr, pc, from_PS, sp, stk_ovf, stk_unf
    );

    modport slave (
        input  hold, jmp, jmp_nz, dont_jmp, call, ret, clr_err, jmp_addr,
        output pm_addr, pc, from_PS, sp, stk_ovf, stk_unf
    );

endinterface

`default_nettype wire

// File: rtl/program_sequencer_stack_return_stack.sv
// ============================================================================
// Module      : ps_return_stack
// Description : Return-address LIFO; top reads 0 when empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps_return_stack #(
    parameter  int PC_W        = 8,
    parameter  int STACK_DEPTH = 4,
    localparam int SP_W        = $clog2(STACK_DEPTH + 1)
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    input  wire logic            push,
    input  wire logic            pop,
    input  wire logic [PC_W-1:0] din,
    output logic      [PC_W-1:0] top,
    output logic      [SP_W-1:0] sp,
    output logic                 full,
    output logic                 empty
);

    logic [PC_W-1:0] r_mem [STACK_DEPTH];
    logic [SP_W-1:0] r_sp;

    assign full  = (r_sp == SP_W'(STACK_DEPTH));
    assign empty = (r_sp == '0);
    assign sp    = r_sp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sp <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (push && !full && (r_sp == SP_W'(i))) begin
                    r_mem[i] <= din;
                end
            end
            if (push && !full) begin
                r_sp <= r_sp + SP_W'(1);
            end else if (pop && !empty) begin
                r_sp <= r_sp - SP_W'(1);
            end
        end
    end

    always_comb begin
        top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (r_sp == SP_W'(i + 1)) begin
                top = r_mem[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/program_sequencer_stack.sv
// ============================================================================
// Module      : program_sequencer_stack
// Description : Program sequencer with jump, conditional jump, call/return.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_sequencer_stack
    import program_sequencer_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int JMP_W       = 4,
    parameter int STACK_DEPTH = 4
) (
    input wire logic                   clk,
    input wire logic                   reset_n,
    program_sequencer_stack_if.slave   bus
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    logic [PC_W-1:0] r_pc;
    logic            r_ovf;
    logic            r_unf;
    logic [PC_W-1:0] w_inc;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_next;
    logic [PC_W-1:0] w_top;
    logic [SP_W-1:0] w_sp;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_set_ovf;
    logic            w_set_unf;
    sel_t            w_sel;

    assign w_inc    = r_pc + PC_W'(1);
    assign w_target = PC_W'(target_addr(32'(bus.jmp_addr), PC_W, JMP_W));

    always_comb begin
        w_sel = SEL_INC;
        if (bus.hold) begin
            w_sel = SEL_HOLD;
        end else if (bus.ret) begin
            w_sel = SEL_RET;
        end else if (bus.call) begin
            w_sel = SEL_CALL;
        end else if (bus.jmp) begin
            w_sel = SEL_JMP;
        end else if (bus.jmp_nz && !bus.dont_jmp) begin
            w_sel = SEL_JNZ;
        end
    end

    always_comb begin
        w_next    = w_inc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;
        case (w_sel)
            SEL_HOLD: w_next = r_pc;
            SEL_RET: begin
                // Return on an empty stack falls through to pc+1 and flags it.
                if (w_empty) begin
                    w_set_unf = 1'b1;
                end else begin
                    w_next = w_top;
                    w_pop  = 1'b1;
                end
            end
            SEL_CALL: begin
                w_next = w_target;
                if (w_full) begin
                    w_set_ovf = 1'b1;
                end else begin
                    w_push = 1'b1;
                end
            end
            SEL_JMP, SEL_JNZ: w_next = w_target;
            default: w_next = w_inc;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc  <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_pc <= w_next;
            if (w_sel != SEL_HOLD) begin
                r_ovf <= w_set_ovf | (r_ovf & ~bus.clr_err);
                r_unf <= w_set_unf | (r_unf & ~bus.clr_err);
            end
        end
    end

    ps_return_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (w_pop),
        .din     (w_inc),
        .top     (w_top),
        .sp      (w_sp),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign bus.pm_addr = reset_n ? w_next : '0;
    assign bus.pc      = r_pc;
    assign bus.from_PS = w_top;
    assign bus.sp      = w_sp;
    assign bus.stk_ovf = r_ovf;
    assign bus.stk_unf = r_unf;

endmodule

`default_nettype wire
